// File: rtl/mem_port_arb.sv
// Two-requester round-robin arbiter for the main-memory line port. Each grant
// latches one whole-line transaction and holds it on the memory strobes until mem_ack_i.

package param_pkg;
    localparam int MAIN_MEM_LINE_AW = 20;
    localparam int BYTES_PER_LINE   = 8;
endpackage

module mem_port_arb #(
    parameter int MAIN_MEM_LINE_AW = param_pkg::MAIN_MEM_LINE_AW,
    parameter int LINE_W           = param_pkg::BYTES_PER_LINE * 8,
    parameter int TIMEOUT_CYCLES   = 1024
) (
    input  logic                             clk,
    input  logic                             resetn,
    input  logic [1:0]                       rcyc_i,
    input  logic [1:0][MAIN_MEM_LINE_AW-1:0] raddr_i,
    input  logic [1:0]                       wcyc_i,
    input  logic [1:0][MAIN_MEM_LINE_AW-1:0] waddr_i,
    input  logic [1:0][LINE_W-1:0]           wdata_i,
    output logic [1:0]                       ack_o,
    output logic [LINE_W-1:0]                rdata_o,
    output logic                             mem_cyc_o,
    output logic                             mem_we_o,
    output logic [MAIN_MEM_LINE_AW-1:0]      mem_addr_o,
    output logic [LINE_W-1:0]                mem_wdata_o,
    input  logic                             mem_ack_i,
    input  logic [LINE_W-1:0]                mem_rdata_i,
    output logic                             timeout_o,
    output logic                             proto_err_o
);

    localparam int              WD_W   = $clog2(TIMEOUT_CYCLES);
    localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_e;

    state_e                      state_q, state_d;
    logic                        owner_q, owner_d;
    logic                        op_we_q, op_we_d;
    logic [MAIN_MEM_LINE_AW-1:0] addr_q, addr_d;
    logic [LINE_W-1:0]           wdata_q, wdata_d;
    logic                        rr_last_q, rr_last_d;
    logic [WD_W-1:0]             wd_cnt_q, wd_cnt_d;
    logic                        timeout_q, timeout_d;
    logic                        proto_err_q, proto_err_d;

    logic [1:0] req;
    logic       win;
    logic       owner_req;

    // A lone requester wins outright; a collision goes to the port not served last.
    assign req       = rcyc_i | wcyc_i;
    assign win       = (&req) ? ~rr_last_q : req[1];
    assign owner_req = op_we_q ? wcyc_i[owner_q] : rcyc_i[owner_q];

    always_comb begin
        // NOTE: every signal written here gets its default first, so no path can
        // leave one unassigned and infer a latch.
        state_d     = state_q;
        owner_d     = owner_q;
        op_we_d     = op_we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rr_last_d   = rr_last_q;
        wd_cnt_d    = wd_cnt_q;
        timeout_d   = timeout_q;
        proto_err_d = proto_err_q;
        ack_o       = 2'b00;
        rdata_o     = '0;
        mem_cyc_o   = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;

        unique case (state_q)
            ST_IDLE: begin
                if (|req) begin
                    state_d  = ST_BUSY;
                    owner_d  = win;
                    op_we_d  = wcyc_i[win];
                    addr_d   = wcyc_i[win] ? waddr_i[win] : raddr_i[win];
                    wdata_d  = wcyc_i[win] ? wdata_i[win] : '0;
                    wd_cnt_d = '0;
                end
            end
            ST_BUSY: begin
                mem_cyc_o   = 1'b1;
                mem_we_o    = op_we_q;
                mem_addr_o  = addr_q;
                mem_wdata_o = op_we_q ? wdata_q : '0;
                if (!owner_req) begin
                    proto_err_d = 1'b1;
                end
                if (mem_ack_i) begin
                    ack_o     = owner_q ? 2'b10 : 2'b01;
                    rdata_o   = op_we_q ? '0 : mem_rdata_i;
                    rr_last_d = owner_q;
                    state_d   = ST_IDLE;
                end else begin
                    // The watchdog only reports; the transaction is never aborted.
                    if (wd_cnt_q != WD_MAX) begin
                        wd_cnt_d = wd_cnt_q + 1'b1;
                    end
                    if (wd_cnt_d == WD_MAX) begin
                        timeout_d = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge value of every other flop.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= ST_IDLE;
            owner_q     <= 1'b0;
            op_we_q     <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rr_last_q   <= 1'b1;
            wd_cnt_q    <= '0;
            timeout_q   <= 1'b0;
            proto_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            op_we_q     <= op_we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rr_last_q   <= rr_last_d;
            wd_cnt_q    <= wd_cnt_d;
            timeout_q   <= timeout_d;
            proto_err_q <= proto_err_d;
        end
    end

    assign timeout_o   = timeout_q;
    assign proto_err_o = proto_err_q;

endmodule
